// File: rtl/serial_link_arb_pkg.sv
// Shared types and the round-robin pick helper for the serial-link OBI arbiter.
// Request indices are carried as idx_t; up to MaxReq requesters are supported.
package serial_link_arb_pkg;

  localparam int unsigned MaxReq   = 16;
  localparam int unsigned IdxWidth = $clog2(MaxReq);

  typedef logic [IdxWidth-1:0] idx_t;

  typedef struct packed {
    logic valid;
    idx_t idx;
  } pick_t;

  // First set bit of req at or above ptr, wrapping modulo num.
  function automatic pick_t rr_pick(input logic [MaxReq-1:0] req, input idx_t ptr,
                                    input int unsigned num);
    pick_t       res;
    int unsigned cand;
    res = '{valid: 1'b0, idx: '0};
    for (int unsigned k = 0; k < MaxReq; k++) begin
      cand = (32'(ptr) + k) % num;
      if (k < num && !res.valid && req[cand[IdxWidth-1:0]]) begin
        res.valid = 1'b1;
        res.idx   = idx_t'(cand);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/serial_link_arb_id_fifo.sv
// In-order FIFO of requester indices; a push while full is accepted when a pop
// happens in the same cycle, because the head slot is freed at that edge.
module serial_link_arb_id_fifo
  import serial_link_arb_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push,
  input  idx_t                       push_data,
  input  logic                       pop,
  output idx_t                       pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(Depth+1)-1:0] count
);

  localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntWidth = $clog2(Depth + 1);

  idx_t                mem_reg [Depth];
  logic [PtrWidth-1:0] wr_ptr_reg;
  logic [PtrWidth-1:0] rd_ptr_reg;
  logic [CntWidth-1:0] count_reg;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (32'(p) == Depth - 1) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i) begin
    if (push) mem_reg[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign pop_data = mem_reg[rd_ptr_reg];
  assign full     = (count_reg == CntWidth'(Depth));
  assign empty    = (count_reg == '0);
  assign count    = count_reg;

endmodule

// File: rtl/serial_link_obi_arbiter.sv
// Round-robin arbiter sharing one downstream OBI port between NumReq masters;
// the ID FIFO remembers who owns each outstanding response.
module serial_link_obi_arbiter
  import serial_link_arb_pkg::*;
#(
  parameter int unsigned NumReq         = 2,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NumReq-1:0]                    req_i,
  input  logic [NumReq-1:0][AddrWidth-1:0]     addr_i,
  input  logic [NumReq-1:0]                    we_i,
  input  logic [NumReq-1:0][DataWidth/8-1:0]   be_i,
  input  logic [NumReq-1:0][DataWidth-1:0]     wdata_i,
  output logic [NumReq-1:0]                    gnt_o,
  output logic [NumReq-1:0]                    rvalid_o,
  output logic [DataWidth-1:0]                 rdata_o,
  output logic                                 sl_req_o,
  output logic [AddrWidth-1:0]                 sl_addr_o,
  output logic                                 sl_we_o,
  output logic [DataWidth/8-1:0]               sl_be_o,
  output logic [DataWidth-1:0]                 sl_wdata_o,
  input  logic                                 sl_gnt_i,
  input  logic                                 sl_rvalid_i,
  input  logic [DataWidth-1:0]                 sl_rdata_i,
  output logic [$clog2(MaxOutstanding+1)-1:0]  outstanding_o,
  output logic                                 err_unexpected_o
);

  typedef enum logic {ST_IDLE, ST_LOCKED} state_e;

  typedef struct packed {
    logic [AddrWidth-1:0]   addr;
    logic                   we;
    logic [DataWidth/8-1:0] be;
    logic [DataWidth-1:0]   wdata;
  } sl_payload_t;

  state_e            state_reg;
  idx_t              rr_ptr_reg;
  idx_t              lock_idx_reg;
  logic              err_unexpected_reg;
  logic [MaxReq-1:0] req_pad;
  sl_payload_t       payload [MaxReq];
  sl_payload_t       payload_sel;
  pick_t             pick;
  idx_t              sel;
  idx_t              head_idx;
  logic              cand_valid, fifo_full, fifo_empty, handshake, pop;

  for (genvar gi = 0; gi < MaxReq; gi++) begin : g_pad
    if (gi < NumReq) begin : g_used
      assign req_pad[gi] = req_i[gi];
      assign payload[gi] = '{addr: addr_i[gi], we: we_i[gi], be: be_i[gi], wdata: wdata_i[gi]};
    end else begin : g_unused
      assign req_pad[gi] = 1'b0;
      assign payload[gi] = '0;
    end
  end

  // A locked selection overrides arbitration so the address phase stays stable.
  assign pick       = rr_pick(req_pad, rr_ptr_reg, NumReq);
  assign sel        = (state_reg == ST_LOCKED) ? lock_idx_reg : pick.idx;
  assign cand_valid = (state_reg == ST_LOCKED) ? req_pad[lock_idx_reg] : pick.valid;
  assign sl_req_o   = !rst_i && cand_valid && (!fifo_full || sl_rvalid_i);
  assign handshake  = sl_req_o && sl_gnt_i;
  assign pop        = !rst_i && sl_rvalid_i && !fifo_empty;

  assign payload_sel = sl_req_o ? payload[sel] : '0;
  assign sl_addr_o   = payload_sel.addr;
  assign sl_we_o     = payload_sel.we;
  assign sl_be_o     = payload_sel.be;
  assign sl_wdata_o  = payload_sel.wdata;
  assign rdata_o     = sl_rdata_i;

  for (genvar gi = 0; gi < NumReq; gi++) begin : g_route
    assign gnt_o[gi]    = handshake && (sel == idx_t'(gi));
    assign rvalid_o[gi] = pop && (head_idx == idx_t'(gi));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg          <= ST_IDLE;
      rr_ptr_reg         <= '0;
      lock_idx_reg       <= '0;
      err_unexpected_reg <= 1'b0;
    end else begin
      if (sl_rvalid_i && fifo_empty) err_unexpected_reg <= 1'b1;
      case (state_reg)
        ST_IDLE: begin
          if (sl_req_o && !sl_gnt_i) begin
            state_reg    <= ST_LOCKED;
            lock_idx_reg <= sel;
          end
        end
        ST_LOCKED: begin
          if (handshake || !cand_valid) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
      if (handshake) rr_ptr_reg <= (32'(sel) == NumReq - 1) ? '0 : sel + 1'b1;
    end
  end

  assign err_unexpected_o = err_unexpected_reg;

  serial_link_arb_id_fifo #(
    .Depth(MaxOutstanding)
  ) u_id_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .push     (handshake),
    .push_data(sel),
    .pop      (pop),
    .pop_data (head_idx),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (outstanding_o)
  );

endmodule
